packet_to_message_queue: RTL and testbench
==========================================

PACKET_TO_MESSAGE_QUEUE -- requirements
Module: packet_to_message_queue

Interface
REQ-001 The block SHALL have parameter N_BITS_POINTER, default 3, the width of head_pointer_i.
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 4, the number of packet slots (power of two, at least 2).
REQ-003 The block SHALL have parameter N_BITS_QUEUE, default 2, equal to clog2(QUEUE_DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port r_pkt_to_msg_i, input, 1 bit: request from the flits buffer that a complete packet is available.
REQ-007 The block SHALL have port g_pkt_to_msg_o, output, 1 bit: grant; the packet is captured in this cycle.
REQ-008 The block SHALL have port in_link_i, input, `MAX_PACKET_LENGHT*`FLIT_WIDTH bits: packet flits, slot i at bits [(i+1)*`FLIT_WIDTH-1 : i*`FLIT_WIDTH].
REQ-009 The block SHALL have port head_pointer_i, input, N_BITS_POINTER bits: index of the head slot in in_link_i.
REQ-010 The block SHALL have port in_sel_i, input, `MAX_PACKET_LENGHT bits: valid mask, one bit per slot of in_link_i.
REQ-011 The block SHALL have port msg_valid_o, output, 1 bit: the queue holds at least one message.
REQ-012 The block SHALL have port msg_o, output, `MAX_PACKET_LENGHT*`FLIT_WIDTH bits: oldest message, with the head flit in slot 0.
REQ-013 The block SHALL have port msg_sel_o, output, `MAX_PACKET_LENGHT bits: valid mask of msg_o, aligned to msg_o.
REQ-014 The block SHALL have port msg_ack_i, input, 1 bit: the consumer pops the oldest message.
REQ-015 The block SHALL have port count_o, output, N_BITS_QUEUE+1 bits: number of stored messages.

Function
REQ-016 Grant SHALL be combinational: g_pkt_to_msg_o = r_pkt_to_msg_i AND (count_o < QUEUE_DEPTH OR (msg_ack_i AND msg_valid_o)).
REQ-017 On a grant, the block SHALL write the rotated packet into the slot at wr_ptr, where stored flit k = in_link_i slot ((head_pointer_i+k) mod `MAX_PACKET_LENGHT).
REQ-018 On a grant, in_sel_i SHALL be rotated by the same amount and stored with the packet.
REQ-019 A head_pointer_i value of `MAX_PACKET_LENGHT or greater SHALL be treated as 0.
REQ-020 A message SHALL be visible on msg_o, msg_sel_o and msg_valid_o in the cycle after its grant (1-cycle latency).
REQ-021 msg_o and msg_sel_o SHALL be driven from storage at rd_ptr; msg_valid_o = (count_o != 0).
REQ-022 A pop SHALL occur when msg_ack_i and msg_valid_o are both high; msg_ack_i while empty SHALL be ignored.
REQ-023 wr_ptr and rd_ptr SHALL each wrap from QUEUE_DEPTH-1 to 0.
REQ-024 A grant with no pop SHALL increment count_o, a pop with no grant SHALL decrement it, and a grant together with a pop SHALL leave it unchanged.
REQ-025 When full, grant SHALL be given only if a pop happens in the same cycle; the freed slot is written and count_o stays at QUEUE_DEPTH.
REQ-026 When empty, a simultaneous request and ack SHALL produce a grant and no pop; there is no bypass.
REQ-027 Storage contents outside valid slots SHALL be don't-care; msg_o with msg_valid_o low SHALL be don't-care.

Reset
REQ-028 While rst is high at a clock edge, wr_ptr, rd_ptr and count_o SHALL be cleared to 0, giving msg_valid_o=0 in the next cycle.
REQ-029 During the rst cycle, g_pkt_to_msg_o SHALL be forced to 0, so a request made mid-operation is neither granted nor stored.
REQ-030 The storage array SHALL NOT be reset.

Structure
REQ-031 `FLIT_WIDTH and `MAX_PACKET_LENGHT SHALL come from NIC-defines.v; no new shared constants are added.
REQ-032 The rotation SHALL be one sub-module, packet_rotator: purely combinational, parameterised by N_BITS_POINTER, rotating both flits and sel.

Verification (`MAX_PACKET_LENGHT=4, QUEUE_DEPTH=2)
REQ-033 Packet flits A,B,C,D in slots 0..3, head_pointer_i=2, in_sel_i=4'b1111 -> grant in the same cycle; next cycle msg_o slots = C,D,A,B, msg_sel_o=4'b1111, count_o=1.
REQ-034 Head-tail packet in slot 3, in_sel_i=4'b1000, head_pointer_i=3 -> msg_sel_o=4'b0001, slot 0 = the flit.
REQ-035 Two grants then a third request with no ack -> g_pkt_to_msg_o=0 and count_o stays 2; assert ack -> grant in that cycle, count_o stays 2, order preserved.
REQ-036 Five packets pushed and popped interleaved -> both pointers wrap; output order equals input order; count_o never exceeds 2.
REQ-037 Empty queue with request and ack both high -> grant, count_o=1, no underflow.
REQ-038 rst asserted with count_o=2 and a request pending -> no grant; next cycle count_o=0 and msg_valid_o=0.

Source files
------------

// File: rtl/packet_to_message_queue_pkg.sv
// Shared widths and helpers for the packet-to-message queue.
// Flit geometry normally comes from NIC-defines.v; the guarded defaults only apply when built outside the NIC tree.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif

package packet_to_message_queue_pkg;
  localparam int FLIT_W  = `FLIT_WIDTH;
  localparam int MAX_LEN = `MAX_PACKET_LENGHT;
  localparam int PKT_W   = FLIT_W * MAX_LEN;

  // Source slot for output slot k when the head sits at slot start (start < MAX_LEN).
  function automatic int slot_of(input int start, input int k);
    int s;
    s = start + k;
    return (s >= MAX_LEN) ? s - MAX_LEN : s;
  endfunction
endpackage

// File: rtl/packet_to_message_queue_rotator.sv
// Combinational rotator: moves the head flit (and its sel bit) to slot 0.
module packet_rotator
  import packet_to_message_queue_pkg::*;
#(
  parameter int N_BITS_POINTER = 3
) (
  input  logic [PKT_W-1:0]          link,
  input  logic [N_BITS_POINTER-1:0] head,
  input  logic [MAX_LEN-1:0]        sel,
  output logic [PKT_W-1:0]          rot_link,
  output logic [MAX_LEN-1:0]        rot_sel
);
  int start;

  always_comb begin
    // Out-of-range head pointers behave as head at slot 0.
    start    = (int'(head) >= MAX_LEN) ? 0 : int'(head);
    rot_link = '0;
    rot_sel  = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      rot_link[k*FLIT_W +: FLIT_W] = link[slot_of(start, k)*FLIT_W +: FLIT_W];
      rot_sel[k]                   = sel[slot_of(start, k)];
    end
  end
endmodule

// File: rtl/packet_to_message_queue.sv
// Circular message queue: captures whole packets head-aligned and presents the oldest to the consumer.
module packet_to_message_queue
  import packet_to_message_queue_pkg::*;
#(
  parameter int N_BITS_POINTER = 3,
  parameter int QUEUE_DEPTH    = 4,
  parameter int N_BITS_QUEUE   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r_pkt_to_msg_i,
  output logic                      g_pkt_to_msg_o,
  input  logic [PKT_W-1:0]          in_link_i,
  input  logic [N_BITS_POINTER-1:0] head_pointer_i,
  input  logic [MAX_LEN-1:0]        in_sel_i,
  output logic                      msg_valid_o,
  output logic [PKT_W-1:0]          msg_o,
  output logic [MAX_LEN-1:0]        msg_sel_o,
  input  logic                      msg_ack_i,
  output logic [N_BITS_QUEUE:0]     count_o
);
  localparam logic [N_BITS_QUEUE:0] DEPTH_CNT = (N_BITS_QUEUE+1)'(QUEUE_DEPTH);

  logic [N_BITS_QUEUE-1:0] wr_ptr, rd_ptr;
  logic [PKT_W-1:0]        flit_mem [QUEUE_DEPTH];
  logic [MAX_LEN-1:0]      sel_mem  [QUEUE_DEPTH];
  logic [PKT_W-1:0]        rot_link;
  logic [MAX_LEN-1:0]      rot_sel;
  logic                    pop;

  packet_rotator #(.N_BITS_POINTER(N_BITS_POINTER)) u_rot (
    .link     (in_link_i),
    .head     (head_pointer_i),
    .sel      (in_sel_i),
    .rot_link (rot_link),
    .rot_sel  (rot_sel)
  );

  assign msg_valid_o = (count_o != '0);
  assign pop         = msg_ack_i && msg_valid_o;
  // A full queue still accepts when the consumer frees a slot in the same cycle.
  assign g_pkt_to_msg_o = !rst && r_pkt_to_msg_i && ((count_o < DEPTH_CNT) || pop);
  assign msg_o       = flit_mem[rd_ptr];
  assign msg_sel_o   = sel_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (g_pkt_to_msg_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop)            rd_ptr <= rd_ptr + 1'b1;
      case ({g_pkt_to_msg_o, pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (g_pkt_to_msg_o) begin
      flit_mem[wr_ptr] <= rot_link;
      sel_mem[wr_ptr]  <= rot_sel;
    end
  end
endmodule

// File: tb/tb_packet_to_message_queue.sv
// Scoreboard bench for packet_to_message_queue with a 2-deep queue and 4-slot packets.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif

module tb_packet_to_message_queue;
  localparam int FW    = `FLIT_WIDTH;
  localparam int L     = `MAX_PACKET_LENGHT;
  localparam int PW    = FW * L;
  localparam int NP    = 3;
  localparam int DEPTH = 2;
  localparam int NQ    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          gnt;
  logic [PW-1:0] link;
  logic [NP-1:0] hp;
  logic [L-1:0]  sel;
  logic          mvalid;
  logic [PW-1:0] msg;
  logic [L-1:0]  msel;
  logic          ack;
  logic [NQ:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PW-1:0] msg;
    logic [L-1:0]  sel;
  } exp_t;
  exp_t sb[$];

  packet_to_message_queue #(.N_BITS_POINTER(NP), .QUEUE_DEPTH(DEPTH), .N_BITS_QUEUE(NQ)) dut (
    .clk(clk), .rst(rst), .r_pkt_to_msg_i(req), .g_pkt_to_msg_o(gnt),
    .in_link_i(link), .head_pointer_i(hp), .in_sel_i(sel),
    .msg_valid_o(mvalid), .msg_o(msg), .msg_sel_o(msel),
    .msg_ack_i(ack), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Reference: output flit k is input slot (head+k) mod L, head >= L meaning 0.
  function automatic exp_t model_rotate(input logic [PW-1:0] l, input logic [NP-1:0] h, input logic [L-1:0] s);
    exp_t e;
    int   start;
    start = (int'(h) >= L) ? 0 : int'(h);
    for (int k = 0; k < L; k++) begin
      e.msg[k*FW +: FW] = l[((start + k) % L)*FW +: FW];
      e.sel[k]          = s[(start + k) % L];
    end
    return e;
  endfunction

  // Monitor: compares outputs against the scoreboard, then advances the model.
  initial begin
    logic          exp_gnt, exp_pop;
    logic [PW-1:0] mask;
    forever begin
      @(negedge clk);
      check("count", longint'(count), longint'(sb.size()));
      check("msg_valid", longint'(mvalid), longint'(sb.size() != 0));
      if (sb.size() != 0) begin
        mask = '0;
        for (int k = 0; k < L; k++) if (sb[0].sel[k]) mask[k*FW +: FW] = '1;
        check("msg_sel", longint'(msel), longint'(sb[0].sel));
        check("msg_data", longint'(msg & mask), longint'(sb[0].msg & mask));
      end
      exp_pop = ack && (sb.size() != 0);
      exp_gnt = !rst && req && ((sb.size() < DEPTH) || exp_pop);
      check("grant", longint'(gnt), longint'(exp_gnt));
      if (rst) sb.delete();
      else begin
        if (exp_pop) void'(sb.pop_front());
        if (exp_gnt) sb.push_back(model_rotate(link, hp, sel));
      end
    end
  end

  task automatic step(input logic r, input logic [PW-1:0] l, input logic [NP-1:0] h,
                      input logic [L-1:0] s, input logic a);
    req = r; link = l; hp = h; sel = s; ack = a;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; link = '0; hp = '0; sel = '0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle(1);

    // Head at slot 2: A,B,C,D -> C,D,A,B.
    step(1'b1, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 3'd2, 4'b1111, 1'b0);
    @(negedge clk);
    check("rot_head2", longint'(msg), longint'({8'hBB, 8'hAA, 8'hDD, 8'hCC}));
    @(posedge clk); #2;
    drain();

    // Single head-tail flit in slot 3.
    step(1'b1, {8'h5A, 8'h11, 8'h22, 8'h33}, 3'd3, 4'b1000, 1'b0);
    @(negedge clk);
    check("ht_sel", longint'(msel), 4'b0001);
    check("ht_flit", longint'(msg[FW-1:0]), 8'h5A);
    @(posedge clk); #2;
    drain();

    // Fill, blocked request, then request with ack while full.
    step(1'b1, {8'h14, 8'h13, 8'h12, 8'h11}, 3'd0, 4'b1111, 1'b0);
    step(1'b1, {8'h24, 8'h23, 8'h22, 8'h21}, 3'd1, 4'b0111, 1'b0);
    step(1'b1, {8'h34, 8'h33, 8'h32, 8'h31}, 3'd2, 4'b1111, 1'b0);
    step(1'b1, {8'h44, 8'h43, 8'h42, 8'h41}, 3'd3, 4'b1111, 1'b1);
    drain();

    // Empty queue with request and ack together.
    step(1'b1, {8'h54, 8'h53, 8'h52, 8'h51}, 3'd1, 4'b0011, 1'b1);
    drain();

    // Out-of-range head pointers act as zero.
    for (int h = L; h < (1 << NP); h++) begin
      step(1'b1, {8'h64, 8'h63, 8'h62, 8'h61} + PW'(h), NP'(h), 4'b1111, 1'b0);
      drain();
    end

    // Reset while full with a request pending.
    step(1'b1, {8'h74, 8'h73, 8'h72, 8'h71}, 3'd0, 4'b1111, 1'b0);
    step(1'b1, {8'h84, 8'h83, 8'h82, 8'h81}, 3'd2, 4'b1111, 1'b0);
    rst = 1'b1;
    step(1'b1, {8'h94, 8'h93, 8'h92, 8'h91}, 3'd1, 4'b1111, 1'b0);
    rst = 1'b0;
    idle(2);

    // Randomized traffic with interleaved pushes and pops.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom} & {PW{1'b1}},
           NP'($urandom_range(0, (1 << NP) - 1)), L'($urandom), 1'($urandom_range(0, 1)));
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
